// File: rtl/ctrl_loop_seq_pkg.sv
// Shared types for the control-loop sequencer: FSM state and the bundled
// {start,valid,stop} control word carried through the delay line.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_reg;

  function automatic ctrl_reg pack_ctrl(input logic start, input logic valid, input logic stop);
    ctrl_reg w;
    w.start = start;
    w.valid = valid;
    w.stop  = stop;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_loop_seq_if.sv
// Control bus between the sequencer (master) and one compute stage (slave).
interface ctrl_loop_seq_if;
  logic [31:0] delay;
  logic        start;
  logic        valid;
  logic        ready;
  logic        stop;

  modport master (output delay, output start, output valid, output stop, input ready);
  modport slave  (input delay, input start, input valid, input stop, output ready);
endinterface

// File: rtl/ctrl_loop_seq_delay_line.sv
// Fixed-depth shift register of control words, modelling the stage's pipeline latency.
module ctrl_delay_line
  import ctrl_pkg::*;
#(
  parameter int unsigned DELAY = 3
) (
  input  logic    clk,
  input  logic    xrst,
  input  ctrl_reg din,
  output ctrl_reg dout,
  output logic    tap_stop
);

  ctrl_reg stage_q [DELAY];
  ctrl_reg stage_d [DELAY];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DELAY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DELAY-1];

  // tap_stop is the stop bit one cycle before it reaches dout, so ack can be registered
  generate
    if (DELAY == 1) begin : g_tap_in
      assign tap_stop = din.stop;
    end else begin : g_tap_stage
      assign tap_stop = stage_q[DELAY-2].stop;
    end
  endgenerate

endmodule

// File: rtl/ctrl_loop_seq.sv
// Run sequencer: issues start / per-element valid / stop to one stage and a copy of
// that control delayed by the stage latency; handshakes with the scheduler via req/ack.
module ctrl_loop_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned LWIDTH = 16,
  parameter int unsigned DELAY  = 3
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [LWIDTH-1:0] size,
  output logic              busy,
  output logic              ack,
  ctrl_loop_seq_if.master   ctrl,
  output logic              out_start,
  output logic              out_valid,
  output logic              out_stop
);

  state_t            state_q, state_d;
  logic [LWIDTH-1:0] cnt_q, cnt_d;
  logic [LWIDTH-1:0] size_q, size_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              stop_q, stop_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              beat;
  logic              tap_stop;
  ctrl_reg           dl_in, dl_out;

  assign beat = valid_q && ctrl.ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    start_d = 1'b0;
    valid_d = valid_q;
    stop_d  = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          size_d  = size;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (size_q == '0) begin
          stop_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          valid_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          if (cnt_q == size_q - LWIDTH'(1)) begin
            valid_d = 1'b0;
            stop_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + LWIDTH'(1);
          end
        end
      end
      S_STOP: begin
        ack_d   = tap_stop;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        ack_d = tap_stop;
        if (ack_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      start_q <= start_d;
      valid_q <= valid_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Only accepted beats enter the delay line, so out_valid pulses exactly size times
  assign dl_in = pack_ctrl(start_q, beat, stop_q);

  ctrl_delay_line #(
    .DELAY (DELAY)
  ) u_delay_line (
    .clk      (clk),
    .xrst     (xrst),
    .din      (dl_in),
    .dout     (dl_out),
    .tap_stop (tap_stop)
  );

  assign ctrl.delay = 32'(DELAY);
  assign ctrl.start = start_q;
  assign ctrl.valid = valid_q;
  assign ctrl.stop  = stop_q;
  assign busy       = busy_q;
  assign ack        = ack_q;
  assign out_start  = dl_out.start;
  assign out_valid  = dl_out.valid;
  assign out_stop   = dl_out.stop;

endmodule
